// File: rtl/b2_slide_window_ctrl.sv
// Sliding-window controller: gathers a stream of samples into overlapping
// WIN-sample windows (stride 1) and emits N_OUT windows per frame.
module b2_slide_window_ctrl #(
  parameter int DW    = 7,
  parameter int WIN   = 8,
  parameter int N_OUT = 902
) (
  input  logic          clk,
  input  logic          rst_n_3,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [DW-1:0] Slide_data_0,
  output logic [DW-1:0] Slide_data_1,
  output logic [DW-1:0] Slide_data_2,
  output logic [DW-1:0] Slide_data_3,
  output logic [DW-1:0] Slide_data_4,
  output logic [DW-1:0] Slide_data_5,
  output logic [DW-1:0] Slide_data_6,
  output logic [DW-1:0] Slide_data_7,
  output logic          busy,
  output logic          frame_done,
  output logic [9:0]    out_cnt
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FILL  = 3'd1;
  localparam logic [2:0] SLIDE = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int FW = $clog2(WIN) + 1;

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [DW-1:0] hist [WIN-1];
  logic [DW-1:0] win_q [WIN];
  logic [FW-1:0] fill_cnt;
  logic [9:0]    gen_cnt;
  logic          accept;
  logic          handoff;
  logic          frame_start;

  // In SLIDE the window register can take a new window whenever the current
  // one is leaving or the register is empty.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      FILL:    in_ready = 1'b1;
      SLIDE:   in_ready = out_ready | ~out_valid;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept      = in_valid & in_ready;
  assign handoff     = out_valid & out_ready;
  assign frame_start = (state == IDLE) & start;
  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FILL;
      FILL:    if (accept && fill_cnt == FW'(WIN - 2)) state_nxt = SLIDE;
      SLIDE:   if (accept && gen_cnt == 10'(N_OUT - 1)) state_nxt = DRAIN;
      DRAIN:   if (handoff) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n_3) begin
    if (!rst_n_3) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n_3) begin
    if (!rst_n_3) begin
      fill_cnt <= '0;
      gen_cnt  <= '0;
      out_cnt  <= '0;
    end else if (frame_start) begin
      fill_cnt <= '0;
      gen_cnt  <= '0;
      out_cnt  <= '0;
    end else begin
      if (state == FILL && accept)  fill_cnt <= fill_cnt + FW'(1);
      if (state == SLIDE && accept) gen_cnt  <= gen_cnt + 10'd1;
      if (handoff)                  out_cnt  <= out_cnt + 10'd1;
    end
  end

  // hist[0] is the oldest retained sample; every accepted sample shifts in at the top.
  always_ff @(posedge clk or negedge rst_n_3) begin
    if (!rst_n_3) begin
      for (int i = 0; i < WIN - 1; i++) hist[i] <= '0;
    end else if (frame_start) begin
      for (int i = 0; i < WIN - 1; i++) hist[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < WIN - 2; i++) hist[i] <= hist[i + 1];
      hist[WIN-2] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n_3) begin
    if (!rst_n_3) begin
      for (int i = 0; i < WIN; i++) win_q[i] <= '0;
    end else if (state == SLIDE && accept) begin
      for (int i = 0; i < WIN - 1; i++) win_q[i] <= hist[i];
      win_q[WIN-1] <= in_data;
    end
  end

  // A fresh load wins over a handoff, so back-to-back windows keep out_valid high.
  always_ff @(posedge clk or negedge rst_n_3) begin
    if (!rst_n_3)                      out_valid <= 1'b0;
    else if (state == SLIDE && accept) out_valid <= 1'b1;
    else if (handoff)                  out_valid <= 1'b0;
  end

  assign Slide_data_0 = win_q[0];
  assign Slide_data_1 = win_q[1];
  assign Slide_data_2 = win_q[2];
  assign Slide_data_3 = win_q[3];
  assign Slide_data_4 = win_q[4];
  assign Slide_data_5 = win_q[5];
  assign Slide_data_6 = win_q[6];
  assign Slide_data_7 = win_q[7];

endmodule

// File: tb/tb_b2_slide_window_ctrl.sv
// Directed bench for b2_slide_window_ctrl: ramp frames with gaps, stalls,
// ignored start, mid-frame reset and a stalled final window.
module tb_b2_slide_window_ctrl;

  logic       clk = 1'b0;
  logic       rst_n_3;
  logic       start;
  logic       in_valid;
  logic [6:0] in_data;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic [6:0] Slide_data_0, Slide_data_1, Slide_data_2, Slide_data_3;
  logic [6:0] Slide_data_4, Slide_data_5, Slide_data_6, Slide_data_7;
  logic       busy;
  logic       frame_done;
  logic [9:0] out_cnt;
  logic [55:0] obs_win;

  int n_assert;
  int n_fail;
  int sent;
  int got;
  int fd_cnt;
  bit fv_checked;
  bit prev_rdy;
  bit prev_load;

  b2_slide_window_ctrl dut (
    .clk(clk), .rst_n_3(rst_n_3), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_ready(out_ready), .out_valid(out_valid),
    .Slide_data_0(Slide_data_0), .Slide_data_1(Slide_data_1),
    .Slide_data_2(Slide_data_2), .Slide_data_3(Slide_data_3),
    .Slide_data_4(Slide_data_4), .Slide_data_5(Slide_data_5),
    .Slide_data_6(Slide_data_6), .Slide_data_7(Slide_data_7),
    .busy(busy), .frame_done(frame_done), .out_cnt(out_cnt)
  );

  always #5 clk = ~clk;

  assign obs_win = {Slide_data_7, Slide_data_6, Slide_data_5, Slide_data_4,
                    Slide_data_3, Slide_data_2, Slide_data_1, Slide_data_0};

  // Window w of a ramp frame holds samples w..w+7, wrapped to 7 bits.
  function automatic logic [55:0] exp_win(input int w);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i*7 +: 7] = 7'((w + i) % 128);
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, check 1 ns later, update model at the rising edge.
  task automatic apply_stimulus(input logic v, input logic r, input logic s);
    logic acc;
    logic hand;
    in_valid  = v;
    out_ready = r;
    start     = s;
    in_data   = 7'(sent % 128);
    #1;
    if (prev_rdy) check_output("out_valid_model", 64'(out_valid), 64'(prev_load));
    if (!fv_checked && sent == 8 && got == 0) begin
      check_output("first_window_valid", 64'(out_valid), 64'd1);
      fv_checked = 1'b1;
    end
    acc  = in_valid & in_ready;
    hand = out_valid & out_ready;
    if (hand) begin
      check_output("window_lanes", 64'(obs_win), 64'(exp_win(got)));
      check_output("out_cnt_at_handoff", 64'(out_cnt), 64'(got));
    end
    if (frame_done) fd_cnt++;
    prev_load = acc && (sent >= 7);
    prev_rdy  = r;
    @(posedge clk);
    if (acc)  sent++;
    if (hand) got++;
    @(negedge clk);
  endtask

  // mode: 0 continuous, 1 input gaps, 2 output stall, 3 start while busy,
  //       4 final-window stall, 5 reset at out_cnt=400
  task automatic run_frame(input int mode);
    int cyc;
    bit stalled;
    bit started;
    bit aborted;
    logic v;
    logic s;
    logic [55:0] held;
    sent = 0; got = 0; fd_cnt = 0;
    fv_checked = 1'b0; prev_rdy = 1'b0; prev_load = 1'b0;
    stalled = 1'b0; started = 1'b0; aborted = 1'b0;
    apply_stimulus(1'b0, 1'b1, 1'b1);
    check_output("busy_after_start", 64'(busy), 64'd1);
    cyc = 0;
    while (fd_cnt == 0 && cyc < 4000) begin
      v = 1'b1;
      s = 1'b0;
      if (mode == 1) v = (cyc % 2 == 0);
      if (mode == 3 && got == 100 && !started) begin
        s = 1'b1;
        started = 1'b1;
      end
      if (mode == 2 && got == 300 && !stalled) begin
        stalled = 1'b1;
        held = obs_win;
        check_output("pre_stall_window", 64'(held), 64'(exp_win(300)));
        for (int k = 0; k < 3; k++) begin
          in_valid = 1'b1; out_ready = 1'b0; start = 1'b0;
          #1;
          check_output("stall_window_stable", 64'(obs_win), 64'(held));
          check_output("stall_out_valid", 64'(out_valid), 64'd1);
          check_output("stall_in_ready", 64'(in_ready), 64'd0);
          @(posedge clk);
          @(negedge clk);
        end
        prev_rdy = 1'b0;
      end
      if (mode == 4 && sent == 909 && !stalled) begin
        stalled = 1'b1;
        for (int k = 0; k < 3; k++) begin
          in_valid = 1'b1; out_ready = 1'b0; start = 1'b0;
          #1;
          check_output("drain_in_ready", 64'(in_ready), 64'd0);
          check_output("drain_busy", 64'(busy), 64'd1);
          check_output("drain_out_valid", 64'(out_valid), 64'd1);
          check_output("drain_no_done", 64'(frame_done), 64'd0);
          @(posedge clk);
          @(negedge clk);
        end
        prev_rdy = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b0);
        #1;
        check_output("done_after_ready", 64'(frame_done), 64'd1);
      end
      if (mode == 5 && got == 400) begin
        rst_n_3 = 1'b0;
        #1;
        check_output("rst_in_ready", 64'(in_ready), 64'd0);
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_lanes", 64'(obs_win), 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        check_output("rst_frame_done", 64'(frame_done), 64'd0);
        check_output("rst_out_cnt", 64'(out_cnt), 64'd0);
        check_output("rst_no_done_seen", 64'(fd_cnt), 64'd0);
        aborted = 1'b1;
        break;
      end
      apply_stimulus(v, 1'b1, s);
      cyc++;
    end
    if (!aborted) begin
      check_output("frame_timeout", 64'(fd_cnt > 0), 64'd1);
      for (int k = 0; k < 3; k++) apply_stimulus(1'b0, 1'b1, 1'b0);
      check_output("frame_done_once", 64'(fd_cnt), 64'd1);
      check_output("windows_handed", 64'(got), 64'd902);
      check_output("samples_taken", 64'(sent), 64'd909);
      check_output("out_cnt_final", 64'(out_cnt), 64'd902);
      check_output("idle_busy", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    sent = 0; got = 0; fd_cnt = 0;
    fv_checked = 1'b0; prev_rdy = 1'b0; prev_load = 1'b0;
    rst_n_3 = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #1;
    check_output("reset_out_valid", 64'(out_valid), 64'd0);
    check_output("reset_in_ready", 64'(in_ready), 64'd0);
    check_output("reset_lanes", 64'(obs_win), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_out_cnt", 64'(out_cnt), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n_3 = 1'b1;
    in_valid = 1'b1;
    #1;
    check_output("idle_in_ready", 64'(in_ready), 64'd0);
    check_output("idle_wait_busy", 64'(busy), 64'd0);
    @(negedge clk);

    $display("[TB] continuous ramp");
    run_frame(0);
    $display("[TB] input gaps");
    run_frame(1);
    $display("[TB] output backpressure");
    run_frame(2);
    $display("[TB] start while busy");
    run_frame(3);
    $display("[TB] reset mid-frame");
    run_frame(5);
    @(negedge clk);
    check_output("rst_hold_no_done", 64'(frame_done), 64'd0);
    @(negedge clk);
    rst_n_3 = 1'b1;
    @(negedge clk);
    check_output("post_rst_idle", 64'(busy), 64'd0);
    run_frame(0);
    $display("[TB] final-window stall");
    run_frame(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/b2_slide_window_ctrl.md
B2_SLIDE_WINDOW_CTRL -- requirements
Module: b2_slide_window_ctrl

Interface
REQ-001 Parameter DW, default 7: sample width in bits.
REQ-002 Parameter WIN, default 8: window length, equal to the number of output lanes.
REQ-003 Parameter N_OUT, default 902: windows emitted per frame.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n_3  input  1  reset; asynchronous, active-low.
REQ-006 start  input  1  single-cycle frame start request.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_data  input  DW  incoming sample.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 out_ready  input  1  downstream accepts the window this cycle.
REQ-011 out_valid  output  1  Slide_data_0..7 hold a valid window.
REQ-012 Slide_data_0..Slide_data_7  output  DW each  window lanes; lane 0 holds the oldest sample, lane 7 the newest.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 frame_done  output  1  single-cycle pulse when the frame completes.
REQ-015 out_cnt  output  10  number of windows handed off in the current frame.

Function
REQ-016 Input handshake: a sample is accepted when in_valid and in_ready are both high; output handshake: a window is handed off when out_valid and out_ready are both high.
REQ-017 FSM states: IDLE, FILL, SLIDE, DRAIN, DONE.
REQ-018 IDLE: in_ready=0, out_valid=0; start=1 -> FILL, clearing the history register and out_cnt and the fill counter.
REQ-019 start is ignored in every state except IDLE.
REQ-020 FILL: in_ready=1; each accepted sample shifts into a (WIN-1)-deep history register.
REQ-021 FILL exit: after WIN-1 samples are accepted -> SLIDE.
REQ-022 FILL emits no windows.
REQ-023 SLIDE in_ready: equals (out_ready OR NOT out_valid), giving single-register pipelining with a throughput of one window per cycle.
REQ-024 SLIDE accepted sample, output: the window register loads {history, sample}, with history[oldest] on lane 0 and the new sample on lane 7; out_valid is set on the next cycle, a latency of 1 cycle.
REQ-025 SLIDE accepted sample, history: history shifts by one, so the stride is 1 sample.
REQ-026 Simultaneous output handoff and input acceptance in the same cycle: the new window replaces the old one and out_valid stays 1.
REQ-027 Output handoff with no input accepted in the same cycle: out_valid goes to 0.
REQ-028 While out_valid=1 and out_ready=0, Slide_data_0..7 and out_valid hold stable.
REQ-029 out_cnt increments by 1 on each output handoff.
REQ-030 Window generation count: a generation counter counts windows loaded.
REQ-031 SLIDE exit: when the N_OUT-th window is loaded -> DRAIN; in_ready=0 from that cycle onward.
REQ-032 DRAIN: in_ready=0; on the handoff of the final window -> DONE.
REQ-033 DONE: frame_done=1 for exactly one cycle, then -> IDLE.
REQ-034 DONE: out_cnt holds N_OUT until the next start.
REQ-035 Each frame consumes exactly N_OUT+WIN-1 samples (909 at the defaults).
REQ-036 Samples are never dropped: any in_valid gap stalls FILL or SLIDE without corrupting history.
REQ-037 The block performs no arithmetic on sample data; samples pass through unmodified at DW bits.

Reset
REQ-038 rst_n_3=0 immediately forces: state=IDLE; in_ready=0, out_valid=0, Slide_data_0..7=0, busy=0, frame_done=0, out_cnt=0; history and counters = 0.
REQ-039 Reset asserted in any state, including mid-SLIDE with a window pending, aborts the frame with no frame_done pulse.
REQ-040 After reset release the block waits in IDLE for start.

Verification
REQ-041 Continuous ramp: start, in_data=k mod 128 for k=0..908, in_valid=1, out_ready=1 -> first out_valid 1 cycle after the 8th accept, with lanes 0..7=0..7; the 902nd window has lanes=5..12; frame_done pulses once; out_cnt=902; exactly 909 samples accepted.
REQ-042 Backpressure: out_ready=0 for 3 cycles mid-SLIDE -> Slide_data and out_valid stable, in_ready=0 during the stall, no sample lost, next window continues the ramp.
REQ-043 Input gaps: in_valid toggled 1,0,1,0 during FILL and SLIDE -> window contents identical to the continuous-ramp case, out_valid low in gap-induced bubbles.
REQ-044 Start during busy: start pulsed at out_cnt=100 -> no effect; frame completes normally with out_cnt=902.
REQ-045 Reset mid-frame: rst_n_3=0 at out_cnt=400 -> all outputs 0 immediately, no frame_done; after release and a new start, the frame produces 902 windows again from lane 0 = first new sample.
REQ-046 Final-window stall: out_ready=0 when the 902nd window is loaded -> state DRAIN, in_ready=0, and frame_done occurs 1 cycle after out_ready rises.
